// File: rtl/cmd_wb_responder.sv
// Command/response word responder that turns each accepted 34-bit command into
// at most one pipelined Wishbone single-word access and exactly one response word.
module cmd_wb_responder #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_stb,
  input  logic [33:0] cmd_word,
  output logic        cmd_busy,
  output logic        rsp_stb,
  output logic [33:0] rsp_word,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [31:0] wb_adr,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack,
  input  logic        wb_err,
  input  logic        wb_stall
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  localparam logic [1:0] OP_SETADDR = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_READ    = 2'b10;
  localparam logic [1:0] OP_NOP     = 2'b11;
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic        inc_q;
  logic [7:0]  tcnt_q;
  logic [31:0] adr_q;
  logic [31:0] dat_q;
  logic        we_q;
  logic [33:0] rsp_q;
  logic [33:0] rsp_d;
  logic        rsp_load;
  logic        bump;
  logic        accept;

  // Successful completion: writes echo the address used, reads return bus data.
  function automatic logic [33:0] ok_word(input logic we, input logic [31:0] adr,
                                          input logic [31:0] rdata);
    return we ? {OP_WRITE, adr} : {OP_READ, rdata};
  endfunction

  assign accept = cmd_stb && (state_q == S_IDLE);

  always_comb begin
    state_d  = state_q;
    rsp_load = 1'b0;
    rsp_d    = rsp_q;
    bump     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd_word[33:32])
            OP_SETADDR: begin
              state_d  = S_RESP;
              rsp_load = 1'b1;
              rsp_d    = {OP_SETADDR, cmd_word[31:2], 2'b00};
            end
            OP_NOP: begin
              state_d  = S_RESP;
              rsp_load = 1'b1;
              rsp_d    = {OP_NOP, 32'hFFFF_FFFF};
            end
            default: state_d = S_REQ;
          endcase
        end
      end
      S_REQ: begin
        // A completion sampled together with the accepted strobe is honoured.
        if (!wb_stall) begin
          if (wb_err) begin
            state_d  = S_RESP;
            rsp_load = 1'b1;
            rsp_d    = {2'b11, adr_q};
          end else if (wb_ack) begin
            state_d  = S_RESP;
            rsp_load = 1'b1;
            rsp_d    = ok_word(we_q, adr_q, wb_dat_i);
            bump     = inc_q;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (wb_err || (!wb_ack && tcnt_q == TO_LAST)) begin
          state_d  = S_RESP;
          rsp_load = 1'b1;
          rsp_d    = {2'b11, adr_q};
        end else if (wb_ack) begin
          state_d  = S_RESP;
          rsp_load = 1'b1;
          rsp_d    = ok_word(we_q, adr_q, wb_dat_i);
          bump     = inc_q;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      inc_q   <= 1'b0;
      tcnt_q  <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      if (rsp_load) rsp_q <= rsp_d;
      if (bump) addr_q <= addr_q + 32'd4;
      if (accept) begin
        tcnt_q <= '0;
        case (cmd_word[33:32])
          OP_SETADDR: begin
            addr_q <= {cmd_word[31:2], 2'b00};
            inc_q  <= cmd_word[0];
          end
          OP_WRITE: begin
            adr_q <= addr_q;
            we_q  <= 1'b1;
            dat_q <= cmd_word[31:0];
          end
          OP_READ: begin
            adr_q <= addr_q;
            we_q  <= 1'b0;
          end
          default: ;
        endcase
      end else if (state_q == S_WAIT) begin
        tcnt_q <= tcnt_q + 8'd1;
      end
    end
  end

  assign cmd_busy = (state_q != S_IDLE);
  assign rsp_stb  = (state_q == S_RESP);
  assign rsp_word = rsp_q;
  assign wb_cyc   = (state_q == S_REQ) || (state_q == S_WAIT);
  assign wb_stb   = (state_q == S_REQ);
  assign wb_we    = we_q;
  assign wb_adr   = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel   = wb_cyc ? 4'hF : 4'h0;

endmodule

// File: tb/tb_cmd_wb_responder.sv
// Bench for cmd_wb_responder: scripted Wishbone slave plus a response scoreboard.
module tb_cmd_wb_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_stb = 1'b0;
  logic [33:0] cmd_word = '0;
  logic        cmd_busy, rsp_stb;
  logic [33:0] rsp_word;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_dat_o;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack = 1'b0;
  logic        wb_err = 1'b0;
  logic        wb_stall = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_rsp    = 0;
  int n_pushed = 0;
  logic [33:0] exp_q[$];

  // Slave behaviour: stall count in REQ, completion delay (0 = with strobe), kind.
  int          cfg_stall = 0;
  int          cfg_delay = 0;
  int          cfg_mode  = 0;  // 0 ack, 1 err, 2 ack+err, 3 silent
  logic [31:0] cfg_data  = '0;
  int          stall_left = 0;
  int          wcnt = 0;

  always #5 clk = ~clk;

  cmd_wb_responder #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .cmd_stb(cmd_stb), .cmd_word(cmd_word),
    .cmd_busy(cmd_busy), .rsp_stb(rsp_stb), .rsp_word(rsp_word),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_dat_o(wb_dat_o), .wb_sel(wb_sel), .wb_dat_i(wb_dat_i),
    .wb_ack(wb_ack), .wb_err(wb_err), .wb_stall(wb_stall)
  );

  always @(posedge clk) begin
    #1;
    wb_dat_i = cfg_data;
    wb_ack   = 1'b0;
    wb_err   = 1'b0;
    if (wb_cyc !== 1'b1) begin
      wb_stall   = 1'b0;
      stall_left = cfg_stall;
      wcnt       = 0;
    end else if (wb_stb === 1'b1) begin
      if (stall_left > 0) begin
        wb_stall = 1'b1;
        stall_left--;
      end else begin
        wb_stall = 1'b0;
        if (cfg_delay == 0) begin
          wb_ack = (cfg_mode == 0 || cfg_mode == 2);
          wb_err = (cfg_mode == 1 || cfg_mode == 2);
        end
      end
    end else begin
      wb_stall = 1'b0;
      wcnt++;
      if (wcnt == cfg_delay) begin
        wb_ack = (cfg_mode == 0 || cfg_mode == 2);
        wb_err = (cfg_mode == 1 || cfg_mode == 2);
      end
    end
  end

  always @(negedge clk) begin
    if (rsp_stb === 1'b1) begin
      logic [33:0] e;
      n_checks++;
      n_rsp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rsp got=%h expected=none", rsp_word);
      end else begin
        e = exp_q.pop_front();
        if (rsp_word !== e) begin
          n_fail++;
          $display("FAIL rsp_word got=%h expected=%h", rsp_word, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rsp(input logic [33:0] w);
    exp_q.push_back(w);
    n_pushed++;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] pl);
    int g = 0;
    while (cmd_busy && g < 200) begin step(); g++; end
    cmd_stb  = 1'b1;
    cmd_word = {op, pl};
    step();
    cmd_stb  = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (cmd_busy !== 1'b0 && g < 200) begin step(); g++; end
    n_checks++;
    if (g >= 200) begin
      n_fail++;
      $display("FAIL wait_idle got=busy expected=idle");
    end
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    n_checks++;
    if ({cmd_busy, rsp_stb, wb_cyc, wb_stb, wb_we} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%b expected=00000", {cmd_busy, rsp_stb, wb_cyc, wb_stb, wb_we});
    end
    n_checks++;
    if (rsp_word !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_rsp_word got=%h expected=0", rsp_word);
    end
    n_checks++;
    if ({wb_adr, wb_dat_o, wb_sel} !== 68'h0) begin
      n_fail++;
      $display("FAIL reset_bus got=%h/%h/%h expected=0", wb_adr, wb_dat_o, wb_sel);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_setaddr_read();
    expect_rsp({2'b00, 32'h0000_1000});
    issue(2'b00, 32'h0000_1001);
    n_checks++;
    if ({rsp_stb, cmd_busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL setaddr_resp_cycle got=%b expected=11", {rsp_stb, cmd_busy});
    end
    step();
    n_checks++;
    if ({rsp_stb, cmd_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL setaddr_after got=%b expected=00", {rsp_stb, cmd_busy});
    end
    cfg_stall = 0; cfg_delay = 3; cfg_mode = 0; cfg_data = 32'hDEAD_BEEF;
    expect_rsp({2'b10, 32'hDEAD_BEEF});
    issue(2'b10, 32'h0);
    n_checks++;
    if ({wb_cyc, wb_stb, wb_we, wb_sel, wb_adr} !== {3'b110, 4'hF, 32'h0000_1000}) begin
      n_fail++;
      $display("FAIL read_req got=%b%b%b %h %h expected=110 f 00001000",
               wb_cyc, wb_stb, wb_we, wb_sel, wb_adr);
    end
    wait_idle();
    cfg_delay = 0; cfg_data = 32'h0BAD_F00D;
    expect_rsp({2'b10, 32'h0BAD_F00D});
    issue(2'b10, 32'h0);
    n_checks++;
    if (wb_adr !== 32'h0000_1004) begin
      n_fail++;
      $display("FAIL read_postinc got=%h expected=00001004", wb_adr);
    end
    step();
    n_checks++;
    if (rsp_stb !== 1'b1) begin
      n_fail++;
      $display("FAIL min_latency got=%b expected=1", rsp_stb);
    end
    wait_idle();
  endtask

  task automatic test_write_stall();
    int stb_cnt = 0;
    int g = 0;
    logic bad = 1'b0;
    expect_rsp({2'b00, 32'h0000_2000});
    issue(2'b00, 32'h0000_2000);
    wait_idle();
    cfg_stall = 2; cfg_delay = 1; cfg_mode = 0;
    expect_rsp({2'b01, 32'h0000_2000});
    issue(2'b01, 32'h1234_5678);
    while (wb_cyc === 1'b1 && g < 100) begin
      if (wb_stb) begin
        stb_cnt++;
        if (wb_we !== 1'b1 || wb_dat_o !== 32'h1234_5678 || wb_adr !== 32'h2000) bad = 1'b1;
      end
      step();
      g++;
    end
    n_checks++;
    if (stb_cnt != 3) begin
      n_fail++;
      $display("FAIL write_stb_cycles got=%0d expected=3", stb_cnt);
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL write_bus_fields got=bad expected=we1 dat12345678 adr2000");
    end
    cfg_stall = 0;
    wait_idle();
  endtask

  task automatic test_bus_error();
    expect_rsp({2'b00, 32'h0000_3000});
    issue(2'b00, 32'h0000_3001);
    wait_idle();
    cfg_delay = 1; cfg_mode = 1;
    expect_rsp({2'b11, 32'h0000_3000});
    issue(2'b10, 32'h0);
    wait_idle();
    cfg_mode = 2;
    expect_rsp({2'b11, 32'h0000_3000});
    issue(2'b01, 32'hAAAA_0000);
    wait_idle();
    cfg_mode = 0; cfg_data = 32'h55AA_55AA;
    expect_rsp({2'b10, 32'h55AA_55AA});
    issue(2'b10, 32'h0);
    n_checks++;
    if (wb_adr !== 32'h0000_3000) begin
      n_fail++;
      $display("FAIL err_no_inc got=%h expected=00003000", wb_adr);
    end
    wait_idle();
  endtask

  task automatic test_timeout();
    int wcyc = 0;
    int g = 0;
    expect_rsp({2'b00, 32'h0000_4000});
    issue(2'b00, 32'h0000_4001);
    wait_idle();
    cfg_mode = 3; cfg_delay = 1;
    expect_rsp({2'b11, 32'h0000_4000});
    issue(2'b10, 32'h0);
    while (rsp_stb !== 1'b1 && g < 100) begin
      if (wb_cyc === 1'b1 && wb_stb === 1'b0) wcyc++;
      step();
      g++;
    end
    n_checks++;
    if (wcyc != 4) begin
      n_fail++;
      $display("FAIL timeout_wait_cycles got=%0d expected=4", wcyc);
    end
    n_checks++;
    if (wb_cyc !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_cyc_drop got=%b expected=0", wb_cyc);
    end
    wait_idle();
    cfg_mode = 0; cfg_data = 32'h0000_0042;
    expect_rsp({2'b10, 32'h0000_0042});
    issue(2'b10, 32'h0);
    n_checks++;
    if (wb_adr !== 32'h0000_4000) begin
      n_fail++;
      $display("FAIL timeout_no_inc got=%h expected=00004000", wb_adr);
    end
    wait_idle();
  endtask

  task automatic test_busy_wrap();
    expect_rsp({2'b00, 32'hFFFF_FFFC});
    issue(2'b00, 32'hFFFF_FFFD);
    wait_idle();
    cfg_delay = 2; cfg_mode = 0; cfg_data = 32'hCAFE_0001;
    expect_rsp({2'b10, 32'hCAFE_0001});
    issue(2'b10, 32'h0);
    cmd_stb  = 1'b1;
    cmd_word = {2'b11, 32'h0};
    step(); step();
    cmd_stb  = 1'b0;
    wait_idle();
    cfg_delay = 0; cfg_data = 32'hCAFE_0002;
    expect_rsp({2'b10, 32'hCAFE_0002});
    issue(2'b10, 32'h0);
    n_checks++;
    if (wb_adr !== 32'h0) begin
      n_fail++;
      $display("FAIL addr_wrap got=%h expected=00000000", wb_adr);
    end
    wait_idle();
    expect_rsp({2'b11, 32'hFFFF_FFFF});
    issue(2'b11, 32'h1234);
    wait_idle();
    n_checks++;
    if (n_rsp != n_pushed) begin
      n_fail++;
      $display("FAIL rsp_count got=%0d expected=%0d", n_rsp, n_pushed);
    end
  endtask

  task automatic test_reset_mid();
    int extra = 0;
    cfg_mode = 3; cfg_delay = 1;
    issue(2'b10, 32'h0);
    step(); step();
    reset = 1'b1;
    step();
    n_checks++;
    if ({wb_cyc, wb_stb, cmd_busy, rsp_stb} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_mid got=%b expected=0000", {wb_cyc, wb_stb, cmd_busy, rsp_stb});
    end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_stb !== 1'b0) extra++;
      step();
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL reset_mid_rsp got=%0d expected=0", extra);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_left got=%0d expected=0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_setaddr_read();
    test_write_stall();
    test_bus_error();
    test_timeout();
    test_busy_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_wb_responder.md
# cmd_wb_responder

Bus-side responder for the 34-bit command/response word interface that the CPU controller's memory path drives (`cmd_stb`/`cmd_word`/`cmd_busy` in, `rsp_stb`/`rsp_word` out). It decodes each accepted command word and runs at most one pipelined-Wishbone single-word transaction per command. It keeps a current-address register with optional post-increment, and returns exactly one response word per command. It sits between the controller and the memory/peripheral Wishbone fabric.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles to wait for `wb_ack`/`wb_err` after the strobe is accepted before reporting a bus error; 8-bit counter.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_stb`  in  1  command valid.
- `cmd_word`  in  34  [33:32] opcode, [31:0] payload.
- `cmd_busy`  out  1  high while a command is in progress; a command is accepted only when `cmd_stb && !cmd_busy`.
- `rsp_stb`  out  1  one-cycle response valid; there is no backpressure.
- `rsp_word`  out  34  [33:32] response code, [31:0] payload.
- `wb_cyc`, `wb_stb`, `wb_we`  out  1 each  Wishbone cycle, strobe and write enable.
- `wb_adr`  out  32  byte address, always word aligned.
- `wb_dat_o`  out  32  write data.
- `wb_sel`  out  4  always 4'hF during a transaction.
- `wb_dat_i`  in  32  read data.
- `wb_ack`, `wb_err`, `wb_stall`  in  1 each  Wishbone acknowledge, error and stall.

## Operation
**Commands** (decoded on acceptance):
- `00` SETADDR: `addr <= {cmd_word[31:2],2'b00}`; `inc <= cmd_word[0]`.
  - No bus cycle.
  - Response `{2'b00, addr_new}`.
- `01` WRITE: write `cmd_word[31:0]` to `addr`.
  - Response `{2'b01, addr_used}`.
- `10` READ: read `addr`.
  - Response `{2'b10, wb_dat_i}`.
- `11` NOP/PING: no bus cycle.
  - Response `{2'b11, 32'hFFFF_FFFF}`.

**Bus error:**
- On `wb_err`, or when the timeout expires, the response is `{2'b11, addr_used}`.
- `addr` is not incremented on a bus error.

**Post-increment:**
- After a successful WRITE/READ with `inc=1`: `addr <= addr + 4`, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.

**State machine:**
- IDLE:
  - SETADDR/NOP accept → RESP.
  - WRITE/READ accept → REQ.
- REQ: `wb_cyc=wb_stb=1`.
  - If `!wb_stall` → WAIT. The same-cycle `wb_ack`/`wb_err` is still honoured: go directly to RESP.
- WAIT: `wb_cyc=1`, `wb_stb=0`, timeout counter running.
  - `wb_ack` → RESP with success.
  - `wb_err` → RESP with error.
  - If `wb_ack` and `wb_err` arrive together, `wb_err` wins.
  - Counter reaches `TIMEOUT_CYCLES` → RESP with error.
- RESP: `rsp_stb=1` for exactly one cycle, `wb_cyc=0` → IDLE.

**Signal rules:**
- The timeout counter is cleared on entry to REQ and counts only in WAIT; REQ cycles spent stalled are not counted.
- `cmd_busy = (state != IDLE)`. A `cmd_stb` asserted while busy is ignored, not queued; the host holds it until `!cmd_busy`.
- `wb_adr`, `wb_we` and `wb_dat_o` are registered at acceptance and stable from REQ through WAIT.

## Timing
- **Reset values:** state IDLE, `addr=0`, `inc=0`, `cmd_busy=0`, `rsp_stb=0`, `rsp_word=0`, `wb_cyc=wb_stb=wb_we=0`, `wb_adr=0`, `wb_dat_o=0`, `wb_sel=0`.
- **Reset mid-transaction:** `wb_cyc`/`wb_stb` drop at that edge and no response is issued for the aborted command.
- **SETADDR/NOP:** accept at edge N; `rsp_stb` high in cycle N+1; `cmd_busy` high in cycle N+1 only; the next command can be accepted at edge N+2.
- **READ/WRITE with zero stall:**
  - Accept at edge N.
  - `wb_stb` high in cycle N+1.
  - `wb_ack` in cycle N+k (k≥1) gives `rsp_stb` in cycle N+k+1.
  - Minimum latency: `rsp_stb` in cycle N+2 when `wb_ack` is sampled with the strobe.
- **`rsp_word`:** valid only while `rsp_stb`=1; it holds its value afterwards.
- **`wb_sel`:** 4'hF while `wb_cyc`=1, otherwise 0.

## Test plan
- **Reset/idle:** assert `reset` → every output takes its reset value; `cmd_busy=0`.
- **SETADDR + READ:** SETADDR 0x0000_1001 (inc=1), then READ with slave data 0xDEAD_BEEF and ack after 3 cycles.
  - SETADDR response is 0x0_0000_1000.
  - READ drives `wb_adr=0x1000`, `wb_we=0`; response is 0x2_DEAD_BEEF.
  - Next READ uses address 0x1004.
- **WRITE with stall:** `wb_stall` high for 2 cycles, then WRITE 0x1234_5678 at 0x2000.
  - `wb_stb` held for 3 cycles, `wb_we=1`, `wb_dat_o=0x1234_5678`.
  - Response is 0x1_0000_2000.
- **Bus error:** `wb_err` in place of `wb_ack` → response 0x3_<addr>; `addr` is not incremented.
  - Also drive `wb_ack` and `wb_err` together → response must be the error.
- **Timeout:** no ack with `TIMEOUT_CYCLES`=4 → error response after 4 WAIT cycles; `wb_cyc` drops in the response cycle.
- **Busy/wrap/reset:**
  - `cmd_stb` asserted while busy → ignored; exactly one response per accepted command.
  - inc=1 at 0xFFFF_FFFC → next access at 0x0.
  - `reset` in WAIT → `wb_cyc=0` next cycle and no `rsp_stb`.
